// File: rtl/spi_slave_reg_ctrl.sv
// Command sequencer behind an SPI slave byte engine: decodes command/data bytes per chip-select
// frame into register-bus read/write requests and stages read data for the following frame.
module spi_slave_reg_ctrl #(
  parameter int unsigned           DATA_WIDTH  = 8,
  parameter int unsigned           ADDR_WIDTH  = 7,
  parameter int unsigned           ACK_TIMEOUT = 15,
  parameter logic [DATA_WIDTH-1:0] ERR_PATTERN = 8'hFF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs_n,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  output logic                  reg_wr,
  output logic                  reg_rd,
  input  logic [DATA_WIDTH-1:0] reg_rdata,
  input  logic                  reg_ack,
  input  logic                  clr_err,
  output logic                  busy,
  output logic                  timeout_err,
  output logic                  abort_err
);

  localparam int unsigned CntW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] TimeoutVal = CntW'(ACK_TIMEOUT);

  typedef enum logic [2:0] {StIdle, StCmd, StData, StBus, StDrain} state_e;

  state_e state_q, state_d;

  logic                  cs_meta_q, cs_s_q;
  logic                  rx_valid_q;
  logic                  byte_stb;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;
  logic [DATA_WIDTH-1:0] reg_wdata_q, reg_wdata_d;
  logic                  reg_wr_q, reg_wr_d;
  logic                  reg_rd_q, reg_rd_d;
  logic                  timeout_err_q, timeout_err_d;
  logic                  abort_err_q, abort_err_d;
  logic                  timeout_hit, bus_done;
  logic                  timeout_set, abort_set;

  assign byte_stb    = rx_valid & ~rx_valid_q;
  assign timeout_hit = (cnt_q == TimeoutVal);
  assign bus_done    = reg_ack | timeout_hit;

  // cs_n is asynchronous to clk; synchronizer idles deasserted (high).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_meta_q  <= 1'b1;
      cs_s_q     <= 1'b1;
      rx_valid_q <= 1'b0;
    end else begin
      cs_meta_q  <= cs_n;
      cs_s_q     <= cs_meta_q;
      rx_valid_q <= rx_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!cs_s_q) state_d = StCmd;
      end
      StCmd: begin
        if (cs_s_q) begin
          state_d = StIdle;
        end else if (byte_stb) begin
          state_d = rx_data[DATA_WIDTH-1] ? StData : StBus;
        end
      end
      StData: begin
        if (byte_stb) begin
          state_d = StBus;
        end else if (cs_s_q) begin
          state_d = StIdle;
        end
      end
      StBus: begin
        if (bus_done) state_d = cs_s_q ? StIdle : StDrain;
      end
      StDrain: begin
        if (cs_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    tx_data_d   = tx_data_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_wr_d    = reg_wr_q;
    reg_rd_d    = reg_rd_q;
    timeout_set = 1'b0;
    abort_set   = 1'b0;
    unique case (state_q)
      StCmd: begin
        if (!cs_s_q && byte_stb) begin
          reg_addr_d = rx_data[ADDR_WIDTH-1:0];
          if (!rx_data[DATA_WIDTH-1]) begin
            reg_rd_d = 1'b1;
            cnt_d    = '0;
          end
        end
      end
      StData: begin
        if (byte_stb) begin
          reg_wdata_d = rx_data;
          reg_wr_d    = 1'b1;
          cnt_d       = '0;
        end else if (cs_s_q) begin
          abort_set = 1'b1;
        end
      end
      StBus: begin
        if (bus_done) begin
          reg_wr_d = 1'b0;
          reg_rd_d = 1'b0;
          // Ack wins over a coincident timeout.
          if (reg_rd_q) tx_data_d = reg_ack ? reg_rdata : ERR_PATTERN;
          if (!reg_ack) timeout_set = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: ;
    endcase
    timeout_err_d = timeout_set | (timeout_err_q & ~clr_err);
    abort_err_d   = abort_set | (abort_err_q & ~clr_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      tx_data_q     <= '0;
      reg_addr_q    <= '0;
      reg_wdata_q   <= '0;
      reg_wr_q      <= 1'b0;
      reg_rd_q      <= 1'b0;
      timeout_err_q <= 1'b0;
      abort_err_q   <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      tx_data_q     <= tx_data_d;
      reg_addr_q    <= reg_addr_d;
      reg_wdata_q   <= reg_wdata_d;
      reg_wr_q      <= reg_wr_d;
      reg_rd_q      <= reg_rd_d;
      timeout_err_q <= timeout_err_d;
      abort_err_q   <= abort_err_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign tx_data     = tx_data_q;
  assign reg_addr    = reg_addr_q;
  assign reg_wdata   = reg_wdata_q;
  assign reg_wr      = reg_wr_q;
  assign reg_rd      = reg_rd_q;
  assign timeout_err = timeout_err_q;
  assign abort_err   = abort_err_q;

endmodule

// File: tb/tb_spi_slave_reg_ctrl.sv
// Directed bench for spi_slave_reg_ctrl: write/read frames, timeout, abort, drain and reset.
module tb_spi_slave_reg_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, cs_n, rx_valid, reg_ack, clr_err;
  logic [7:0] rx_data, reg_rdata, tx_data, reg_wdata;
  logic [6:0] reg_addr;
  logic       reg_wr, reg_rd, busy, timeout_err, abort_err;

  int vectors = 0;
  int miscompares = 0;
  int wr_hi = 0, rd_hi = 0, wr_starts = 0, both_hi = 0;
  logic wr_prev = 1'b0;

  always #5 clk = ~clk;

  spi_slave_reg_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cs_n       (cs_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_wr     (reg_wr),
    .reg_rd     (reg_rd),
    .reg_rdata  (reg_rdata),
    .reg_ack    (reg_ack),
    .clr_err    (clr_err),
    .busy       (busy),
    .timeout_err(timeout_err),
    .abort_err  (abort_err)
  );

  // Request activity monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (reg_wr === 1'b1) wr_hi++;
    if (reg_rd === 1'b1) rd_hi++;
    if (reg_wr === 1'b1 && wr_prev !== 1'b1) wr_starts++;
    if (reg_wr === 1'b1 && reg_rd === 1'b1) both_hi++;
    wr_prev = reg_wr;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic start_frame(output logic [7:0] miso);
    @(negedge clk);
    miso = tx_data;
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic end_frame();
    @(negedge clk);
    cs_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_req(input bit is_wr);
    int n = 0;
    while (((is_wr ? reg_wr : reg_rd) !== 1'b1) && n < 10) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if ((is_wr ? reg_wr : reg_rd) !== 1'b1) begin
      miscompares++;
      $display("FAIL req_rise(wr=%0b): request not seen within 10 cycles, required 1", is_wr);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cs_n = 1'b1; rx_valid = 1'b0; rx_data = '0;
    reg_ack = 1'b0; reg_rdata = '0; clr_err = 1'b0;
    #12;
    vectors++;
    if ({tx_data, reg_wdata, reg_addr} !== 23'd0) begin
      miscompares++;
      $display("FAIL reset_data: got tx=%h wd=%h a=%h, required all 0", tx_data, reg_wdata, reg_addr);
    end
    vectors++;
    if ({reg_wr, reg_rd, busy, timeout_err, abort_err} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got wr/rd/busy/to/ab=%b, required 00000",
               {reg_wr, reg_rd, busy, timeout_err, abort_err});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_write();
    logic [7:0] miso;
    int wr0;
    start_frame(miso);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL write_busy: got %b, required 1", busy);
    end
    wr0 = wr_hi;
    send_byte(8'h85);
    repeat (2) @(negedge clk);
    send_byte(8'h3C);
    wait_req(1'b1);
    repeat (2) @(negedge clk);
    reg_ack = 1'b1;
    @(negedge clk);
    reg_ack = 1'b0;
    vectors++;
    if (reg_wr !== 1'b0) begin
      miscompares++;
      $display("FAIL write_drop: got reg_wr=%b, required 0", reg_wr);
    end
    vectors++;
    if (reg_addr !== 7'h05 || reg_wdata !== 8'h3C) begin
      miscompares++;
      $display("FAIL write_bus: got addr=%h wdata=%h, required 05/3c", reg_addr, reg_wdata);
    end
    end_frame();
    vectors++;
    if (wr_hi - wr0 != 3) begin
      miscompares++;
      $display("FAIL write_len: got %0d cycles, required 3", wr_hi - wr0);
    end
    vectors++;
    if (busy !== 1'b0 || timeout_err !== 1'b0 || abort_err !== 1'b0) begin
      miscompares++;
      $display("FAIL write_end: got busy=%b to=%b ab=%b, required 000", busy, timeout_err, abort_err);
    end
  endtask

  task automatic test_read();
    logic [7:0] miso;
    int rd0;
    start_frame(miso);
    rd0 = rd_hi;
    reg_rdata = 8'hA7;
    send_byte(8'h05);
    wait_req(1'b0);
    @(negedge clk);
    reg_ack = 1'b1;
    @(negedge clk);
    reg_ack = 1'b0;
    reg_rdata = 8'h00;
    vectors++;
    if (reg_rd !== 1'b0 || tx_data !== 8'hA7) begin
      miscompares++;
      $display("FAIL read_done: got rd=%b tx=%h, required 0/a7", reg_rd, tx_data);
    end
    end_frame();
    vectors++;
    if (rd_hi - rd0 != 2 || reg_addr !== 7'h05) begin
      miscompares++;
      $display("FAIL read_len: got %0d cycles addr=%h, required 2/05", rd_hi - rd0, reg_addr);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] miso;
    int rd0, n;
    start_frame(miso);
    vectors++;
    if (miso !== 8'hA7) begin
      miscompares++;
      $display("FAIL miso_pipe: got %h, required a7", miso);
    end
    rd0 = rd_hi;
    reg_rdata = 8'h5A;
    send_byte(8'h12);
    wait_req(1'b0);
    n = 0;
    while (reg_rd === 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (rd_hi - rd0 != 16) begin
      miscompares++;
      $display("FAIL timeout_len: got %0d cycles, required 16", rd_hi - rd0);
    end
    vectors++;
    if (tx_data !== 8'hFF || timeout_err !== 1'b1 || reg_addr !== 7'h12) begin
      miscompares++;
      $display("FAIL timeout_flag: got tx=%h to=%b addr=%h, required ff/1/12",
               tx_data, timeout_err, reg_addr);
    end
    end_frame();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    vectors++;
    if (timeout_err !== 1'b0 || tx_data !== 8'hFF) begin
      miscompares++;
      $display("FAIL timeout_clr: got to=%b tx=%h, required 0/ff", timeout_err, tx_data);
    end
  endtask

  task automatic test_ack_at_limit();
    logic [7:0] miso;
    int rd0;
    start_frame(miso);
    rd0 = rd_hi;
    reg_rdata = 8'hC3;
    send_byte(8'h30);
    wait_req(1'b0);
    repeat (15) @(negedge clk);
    reg_ack = 1'b1;
    @(negedge clk);
    reg_ack = 1'b0;
    end_frame();
    vectors++;
    if (rd_hi - rd0 != 16 || tx_data !== 8'hC3 || timeout_err !== 1'b0) begin
      miscompares++;
      $display("FAIL ack_limit: got %0d cycles tx=%h to=%b, required 16/c3/0",
               rd_hi - rd0, tx_data, timeout_err);
    end
  endtask

  task automatic test_abort();
    logic [7:0] miso;
    int ws0;
    start_frame(miso);
    ws0 = wr_starts;
    send_byte(8'h81);
    repeat (2) @(negedge clk);
    cs_n = 1'b1;
    // Clear coincides with the abort event; set must win.
    repeat (2) @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (abort_err !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_flag: got ab=%b busy=%b, required 1/0", abort_err, busy);
    end
    vectors++;
    if (wr_starts != ws0) begin
      miscompares++;
      $display("FAIL abort_nowrite: got %0d writes, required 0", wr_starts - ws0);
    end
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    vectors++;
    if (abort_err !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_clr: got %b, required 0", abort_err);
    end
  endtask

  task automatic test_drain();
    logic [7:0] miso;
    int ws0;
    start_frame(miso);
    ws0 = wr_starts;
    send_byte(8'h83);
    repeat (2) @(negedge clk);
    send_byte(8'h55);
    wait_req(1'b1);
    reg_ack = 1'b1;
    @(negedge clk);
    reg_ack = 1'b0;
    repeat (2) @(negedge clk);
    send_byte(8'h66);
    repeat (2) @(negedge clk);
    send_byte(8'h77);
    repeat (3) @(negedge clk);
    vectors++;
    if (busy !== 1'b1 || reg_wr !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_state: got busy=%b wr=%b, required 1/0", busy, reg_wr);
    end
    end_frame();
    vectors++;
    if (wr_starts - ws0 != 1 || reg_addr !== 7'h03 || reg_wdata !== 8'h55) begin
      miscompares++;
      $display("FAIL drain_write: got %0d writes addr=%h wd=%h, required 1/03/55",
               wr_starts - ws0, reg_addr, reg_wdata);
    end
    vectors++;
    if (tx_data !== 8'hC3 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_hold: got tx=%h busy=%b, required c3/0", tx_data, busy);
    end
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] miso;
    start_frame(miso);
    send_byte(8'h20);
    wait_req(1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (reg_rd !== 1'b0 || busy !== 1'b0 || tx_data !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_async: got rd=%b busy=%b tx=%h, required 0/0/00", reg_rd, busy, tx_data);
    end
    cs_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    start_frame(miso);
    reg_rdata = 8'h3A;
    send_byte(8'h07);
    wait_req(1'b0);
    reg_ack = 1'b1;
    @(negedge clk);
    reg_ack = 1'b0;
    end_frame();
    vectors++;
    if (tx_data !== 8'h3A || reg_addr !== 7'h07 || busy !== 1'b0 || reg_rd !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_recover: got tx=%h addr=%h busy=%b rd=%b, required 3a/07/0/0",
               tx_data, reg_addr, busy, reg_rd);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_ack_at_limit();
    test_abort();
    test_drain();
    test_reset_mid_read();
    vectors++;
    if (both_hi != 0) begin
      miscompares++;
      $display("FAIL wr_rd_exclusive: got %0d overlapping cycles, required 0", both_hi);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_slave_reg_ctrl.md
Name: spi_slave_reg_ctrl

Overview:
- Command sequencer that sits behind the SPI slave byte engine and turns its received bytes into register-bus transactions.
- Each chip-select frame carries a command byte (R/W flag and address) followed by one data byte for writes.
- Read data is pipelined: a read issued in frame N is presented on tx_data for the slave to shift out in frame N+1.
- The block owns the slave's data_in load value and the handshake to the register bank.

Parameters:
DATA_WIDTH, 8, SPI word width; also the register data width
ADDR_WIDTH, 7, register address width; must equal DATA_WIDTH-1
ACK_TIMEOUT, 15, max clk cycles to wait for reg_ack before abandoning a request
ERR_PATTERN, 8'hFF, value loaded into tx_data when a read times out (DATA_WIDTH bits)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous assert, active-low
cs_n  input  1  raw SPI chip select, asynchronous to clk
rx_data  input  DATA_WIDTH  received byte from the slave engine
rx_valid  input  1  slave data-valid level, synchronous to clk
tx_data  output  DATA_WIDTH  byte loaded by the slave at frame start
reg_addr  output  ADDR_WIDTH  register address
reg_wdata  output  DATA_WIDTH  register write data
reg_wr  output  1  write request level, held until ack or timeout
reg_rd  output  1  read request level, held until ack or timeout
reg_rdata  input  DATA_WIDTH  read data, valid with reg_ack
reg_ack  input  1  single-cycle completion pulse
clr_err  input  1  synchronous clear of the sticky error flags
busy  output  1  high in any state other than IDLE
timeout_err  output  1  sticky: a bus request timed out
abort_err  output  1  sticky: a write frame ended before its data byte

Behaviour:
- Reset (async, rst_n low): every output 0, tx_data 0, FSM in IDLE, cs_n synchronizer flops set to 1, rx_valid history set to 0. Reset mid-request drops reg_wr/reg_rd immediately.
- cs_n passes through a 2-flop synchronizer into cs_s. rx_valid is edge-detected with one register; byte_stb = rx_valid & ~rx_valid_d.
- FSM states are IDLE, CMD, DATA, BUS, DRAIN. Transitions:
  - IDLE: cs_s==0 goes to CMD.
  - CMD: cs_s==1 goes to IDLE with no flag. Otherwise byte_stb latches rw=rx_data[MSB] and reg_addr=rx_data[ADDR_WIDTH-1:0].
    - rw==0 (read): assert reg_rd the next cycle and go to BUS.
    - rw==1 (write): go to DATA.
  - DATA: byte_stb latches reg_wdata=rx_data, asserts reg_wr the next cycle, and goes to BUS. cs_s==1 before byte_stb sets abort_err, issues no write, and goes to IDLE.
  - BUS: the request stays asserted. On reg_ack, or on the timeout counter reaching ACK_TIMEOUT, deassert the request that same cycle. Then go to DRAIN if cs_s==0, else IDLE.
  - DRAIN: ignores all byte_stb (extra bytes in the frame are discarded). cs_s==1 goes to IDLE.
- Chip-select rises during BUS: the request is not aborted. It completes or times out normally, then goes to IDLE.
- Timeout counter:
  - Cleared on entry to BUS, increments each BUS cycle without ack.
  - Timeout occurs when the count equals ACK_TIMEOUT, so the request is held at most ACK_TIMEOUT+1 cycles.
  - On timeout: timeout_err is set; for a read, tx_data=ERR_PATTERN.
- tx_data:
  - Updated only on a read completion: reg_rdata on ack, ERR_PATTERN on timeout.
  - Holds otherwise, including across write frames.
  - The slave samples it at the next frame start. It must therefore settle at least 3 clk before the next cs_n fall.
- reg_ack outside BUS is ignored. An ack on the exact timeout cycle counts as an ack: no error, and data is captured.
- Sticky flags: set by their events, cleared only by clr_err. A set and a clear in the same cycle leaves the flag set.
- reg_wr and reg_rd are never high together.

Test Plan:
- Write frame 0x85, 0x3C; ack 2 cycles after reg_wr rises -> reg_wr high 3 cycles, reg_addr=0x05, reg_wdata=0x3C, no errors, returns to IDLE after cs_n rises.
- Read frame 0x05 with reg_rdata=0xA7 acked after 1 cycle -> reg_rd pulse, tx_data=0xA7 before the next frame; next frame's MISO byte is 0xA7.
- Read frame 0x12, no ack -> reg_rd held exactly ACK_TIMEOUT+1=16 cycles, tx_data=0xFF, timeout_err=1; clr_err -> 0.
- Write frame 0x81 then cs_n rises before the second byte -> no reg_wr, abort_err=1, FSM in IDLE.
- Write frame 0x83, 0x55, 0x66, 0x77 -> exactly one write (addr 3, data 0x55); trailing bytes ignored in DRAIN.
- Assert rst_n low while reg_rd is pending -> reg_rd and busy drop asynchronously; tx_data=0; the next read frame behaves normally.
